alu_op_scheduler: RTL and testbench

Sequential front-end that shares the enable-gated 4-bit ALU function units between two requesters. It accepts one operation at a time through valid/ready handshakes, arbitrating round-robin on contention. It drives the operands and a one-hot function-unit enable for a fixed number of cycles, captures the ALU result, and returns it to the winning requester through a response handshake. It sits between the requester logic and the ALU datapath; unselected units see enable=0 and output 0.

---
 rtl/alu_op_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_alu_op_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
//
// Front-end that shares the enable-gated 4-bit ALU function units between two
// requesters. One operation is in flight at a time. Round-robin arbitration
// picks a requester on contention. The captured operands are driven, together
// with a one-hot unit enable, for ALU_LAT cycles. The ALU result is then
// captured and held on the owner's response port until it is taken.
//
// Parameters
//   ALU_LAT     cycles the unit enable is held before sampling (legal 1..15)
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/ready              request handshake, N = 0, 1
//   reqN_op/a/b                   opcode (one-hot unit index) and operands
//   rspN_valid/ready              response handshake, N = 0, 1
//   rspN_y/c                      result and carry; zero while not valid
//   alu_en                        one-hot function-unit enable, bit = opcode
//   alu_a/alu_b                   operands to all units; zero outside ISSUE
//   alu_y/alu_c                   OR-combined unit result and carry
//   busy                          high whenever not idle

module alu_op_scheduler #(
   parameter int unsigned ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,

   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [2:0] req0_op,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,

   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [2:0] req1_op,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,

   output logic       rsp0_valid,
   input  logic       rsp0_ready,
   output logic [3:0] rsp0_y,
   output logic       rsp0_c,

   output logic       rsp1_valid,
   input  logic       rsp1_ready,
   output logic [3:0] rsp1_y,
   output logic       rsp1_c,

   output logic [7:0] alu_en,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [3:0] alu_y,
   input  logic       alu_c,

   output logic       busy
);

   // Counter reload: the last ISSUE cycle is the one where cnt reaches zero.
   localparam logic [3:0] CntInit = 4'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } state_e;

   state_e     state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic [2:0] op_q, op_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] res_y_q, res_y_d;
   logic       res_c_q, res_c_d;
   logic       owner_q, owner_d;

   logic       grant;
   logic       req_fire;
   logic       rsp_fire;

   // Arbitration: a lone requester wins; on a tie the one not granted last
   // time wins. last_grant resets to 1 so requester 0 takes the first tie.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   always_comb begin
      req0_ready = (state_q == StIdle) && req0_valid && !grant;
      req1_ready = (state_q == StIdle) && req1_valid && grant;
      req_fire   = req0_ready || req1_ready;
   end

   // Response side: only the owner sees valid; data is forced to zero
   // whenever the corresponding valid is low.
   always_comb begin
      rsp0_valid = (state_q == StResp) && !owner_q;
      rsp1_valid = (state_q == StResp) && owner_q;
      rsp0_y     = rsp0_valid ? res_y_q : 4'h0;
      rsp0_c     = rsp0_valid ? res_c_q : 1'b0;
      rsp1_y     = rsp1_valid ? res_y_q : 4'h0;
      rsp1_c     = rsp1_valid ? res_c_q : 1'b0;
      rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
   end

   // ALU drive: units are only enabled, and only see operands, during ISSUE.
   always_comb begin
      alu_en = 8'h00;
      alu_a  = 4'h0;
      alu_b  = 4'h0;
      if (state_q == StIssue) begin
         alu_en = 8'h01 << op_q;
         alu_a  = a_q;
         alu_b  = b_q;
      end
   end

   assign busy = (state_q != StIdle);

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      cnt_d        = cnt_q;
      res_y_d      = res_y_q;
      res_c_d      = res_c_q;
      owner_d      = owner_q;

      unique case (state_q)
         StIdle: begin
            if (req_fire) begin
               owner_d = grant;
               op_d    = grant ? req1_op : req0_op;
               a_d     = grant ? req1_a  : req0_a;
               b_d     = grant ? req1_b  : req0_b;
               cnt_d   = CntInit;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (cnt_q == 4'd0) begin
               res_y_d = alu_y;
               res_c_d = alu_c;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            // Result is held indefinitely until the owner takes it.
            if (rsp_fire) begin
               last_grant_d = owner_q;
               state_d      = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         op_q         <= 3'd0;
         a_q          <= 4'h0;
         b_q          <= 4'h0;
         cnt_q        <= 4'd0;
         res_y_q      <= 4'h0;
         res_c_q      <= 1'b0;
         owner_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         cnt_q        <= cnt_d;
         res_y_q      <= res_y_d;
         res_c_q      <= res_c_d;
         owner_q      <= owner_d;
      end
   end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler
//
// Directed bench for alu_op_scheduler. Two instances share the request and
// response-ready stimulus: one with ALU_LAT=1, one with ALU_LAT=3. Each drives
// its own behavioural ALU unit model.

module tb_alu_op_scheduler;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [2:0] req0_op, req1_op;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       rsp0_ready, rsp1_ready;

   logic       d1_req0_ready, d1_req1_ready, d1_rsp0_valid, d1_rsp1_valid;
   logic [3:0] d1_rsp0_y, d1_rsp1_y, d1_alu_a, d1_alu_b, d1_alu_y;
   logic       d1_rsp0_c, d1_rsp1_c, d1_alu_c, d1_busy;
   logic [7:0] d1_alu_en;

   logic       d3_req0_ready, d3_req1_ready, d3_rsp0_valid, d3_rsp1_valid;
   logic [3:0] d3_rsp0_y, d3_rsp1_y, d3_alu_a, d3_alu_b, d3_alu_y;
   logic       d3_rsp0_c, d3_rsp1_c, d3_alu_c, d3_busy;
   logic [7:0] d3_alu_en;

   int n_cmp = 0;
   int n_bad = 0;

   // Function units: only the enabled one contributes, others output 0.
   function automatic logic [4:0] alu_model(input logic [7:0] en, input logic [3:0] a,
                                            input logic [3:0] b);
      case (en)
         8'h01:   return {1'b0, a & b};
         8'h02:   return {1'b0, a | b};
         8'h04:   return {1'b0, a ^ b};
         8'h08:   return {1'b0, ~a};
         8'h10:   return {1'b0, a} + {1'b0, b};
         8'h20:   return {1'b0, a} - {1'b0, b};
         8'h40:   return {a[3], a[2:0], 1'b0};
         8'h80:   return {a[0], 1'b0, a[3:1]};
         default: return 5'd0;
      endcase
   endfunction

   assign {d1_alu_c, d1_alu_y} = alu_model(d1_alu_en, d1_alu_a, d1_alu_b);
   assign {d3_alu_c, d3_alu_y} = alu_model(d3_alu_en, d3_alu_a, d3_alu_b);

   alu_op_scheduler #(.ALU_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(d1_req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(d1_req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(d1_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(d1_rsp0_y),
      .rsp0_c(d1_rsp0_c),
      .rsp1_valid(d1_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(d1_rsp1_y),
      .rsp1_c(d1_rsp1_c),
      .alu_en(d1_alu_en), .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_y(d1_alu_y),
      .alu_c(d1_alu_c), .busy(d1_busy)
   );

   alu_op_scheduler #(.ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(d3_req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(d3_req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(d3_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(d3_rsp0_y),
      .rsp0_c(d3_rsp0_c),
      .rsp1_valid(d3_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(d3_rsp1_y),
      .rsp1_c(d3_rsp1_c),
      .alu_en(d3_alu_en), .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_y(d3_alu_y),
      .alu_c(d3_alu_c), .busy(d3_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Enables must never have more than one bit set.
   always @(negedge clk) begin
      if (rst_n) begin
         n_cmp++;
         assert ($onehot0(d1_alu_en) && $onehot0(d3_alu_en))
         else begin
            n_bad++;
            $error("FAIL onehot: observed %0h/%0h expected one-hot or zero", d1_alu_en,
                   d3_alu_en);
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      req0_valid = 1'b0; req0_op = 3'd0; req0_a = 4'h0; req0_b = 4'h0;
      req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'h0; req1_b = 4'h0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // Reset values
      #2;
      chk("rst_busy3", d3_busy, 0);
      chk("rst_en3", d3_alu_en, 8'h00);
      chk("rst_a3", d3_alu_a, 0);
      chk("rst_rdy0_3", d3_req0_ready, 0);
      chk("rst_rsp0v3", d3_rsp0_valid, 0);
      chk("rst_rsp1v3", d3_rsp1_valid, 0);
      chk("rst_rsp0y3", d3_rsp0_y, 0);
      chk("rst_busy1", d1_busy, 0);
      chk("rst_en1", d1_alu_en, 8'h00);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single op on LAT=1: req0 OR 1010|0101 = F
      req0_valid = 1'b1; req0_op = 3'd1; req0_a = 4'hA; req0_b = 4'h5; rsp0_ready = 1'b1;
      #1;
      chk("t1_rdy0", d1_req0_ready, 1);
      chk("t1_rdy1", d1_req1_ready, 0);
      chk("t1_busyT", d1_busy, 0);
      tick(); req0_valid = 1'b0; #1;
      chk("t1_en", d1_alu_en, 8'h02);
      chk("t1_a", d1_alu_a, 4'hA);
      chk("t1_b", d1_alu_b, 4'h5);
      chk("t1_busy", d1_busy, 1);
      chk("t1_rspv_early", d1_rsp0_valid, 0);
      tick(); #1;
      chk("t1_en_off", d1_alu_en, 8'h00);
      chk("t1_rsp0v", d1_rsp0_valid, 1);
      chk("t1_rsp0y", d1_rsp0_y, 4'hF);
      chk("t1_rsp0c", d1_rsp0_c, 0);
      chk("t1_rsp1v", d1_rsp1_valid, 0);
      chk("t1_en3_mid", d3_alu_en, 8'h02);
      tick(); #1;
      chk("t1_busy_fall", d1_busy, 0);
      chk("t1_rsp0v_off", d1_rsp0_valid, 0);
      chk("t1_en3_last", d3_alu_en, 8'h02);
      tick(); #1;
      chk("t1_rsp0v3", d3_rsp0_valid, 1);
      chk("t1_rsp0y3", d3_rsp0_y, 4'hF);
      tick(); #1;
      chk("t1_busy3_fall", d3_busy, 0);

      // Latency on LAT=3: req1 ADD 9+8 = 0x11, then backpressure on rsp1
      tick();
      req1_valid = 1'b1; req1_op = 3'd4; req1_a = 4'h9; req1_b = 4'h8; rsp1_ready = 1'b0;
      #1;
      chk("lat_rdy1", d3_req1_ready, 1);
      chk("lat_rdy0", d3_req0_ready, 0);
      for (int i = 1; i <= 3; i++) begin
         tick(); req1_valid = 1'b0; #1;
         chk("lat_en", d3_alu_en, 8'h10);
         chk("lat_a", d3_alu_a, 4'h9);
         chk("lat_b", d3_alu_b, 4'h8);
         chk("lat_rspv_early", d3_rsp1_valid, 0);
      end
      for (int i = 0; i < 5; i++) begin
         tick(); req0_valid = 1'b1; req0_op = 3'd3; #1;
         chk("bp_en", d3_alu_en, 8'h00);
         chk("bp_rsp1v", d3_rsp1_valid, 1);
         chk("bp_rsp1y", d3_rsp1_y, 4'h1);
         chk("bp_rsp1c", d3_rsp1_c, 1);
         chk("bp_busy", d3_busy, 1);
         chk("bp_rdy0", d3_req0_ready, 0);
         chk("bp_rsp0v", d3_rsp0_valid, 0);
      end
      tick(); req0_valid = 1'b0; rsp1_ready = 1'b1; #1;
      chk("bp_release_v", d3_rsp1_valid, 1);
      tick(); #1;
      chk("bp_idle_busy", d3_busy, 0);
      chk("bp_idle_rsp1v", d3_rsp1_valid, 0);
      chk("bp_idle_rsp1y", d3_rsp1_y, 0);

      // Reset in the middle of ISSUE drops the transaction
      req0_valid = 1'b1; req0_op = 3'd2; req0_a = 4'h3; req0_b = 4'h6; #1;
      chk("rs_rdy0", d3_req0_ready, 1);
      tick(); req0_valid = 1'b0; #1;
      chk("rs_en", d3_alu_en, 8'h04);
      chk("rs_busy", d3_busy, 1);
      rst_n = 1'b0; #1;
      chk("rs_en_now", d3_alu_en, 8'h00);
      chk("rs_busy_now", d3_busy, 0);
      chk("rs_rsp0v_now", d3_rsp0_valid, 0);
      chk("rs_a_now", d3_alu_a, 0);
      chk("rs_busy1_now", d1_busy, 0);
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(); #1;
         chk("rs_stale0", d3_rsp0_valid, 0);
         chk("rs_stale1", d3_rsp1_valid, 0);
         chk("rs_idle", d3_busy, 0);
      end

      // Arbitration and back-to-back on LAT=3: grants alternate 0,1,0,1,
      // each handshake exactly 5 cycles after the previous one.
      tick();
      req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'hC; req0_b = 4'hA;
      req1_valid = 1'b1; req1_op = 3'd5; req1_a = 4'h5; req1_b = 4'h7;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         logic g;
         g = 1'(k % 2);
         chk("arb_rdy0", d3_req0_ready, {7'd0, !g});
         chk("arb_rdy1", d3_req1_ready, {7'd0, g});
         for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            chk("arb_en", d3_alu_en, g ? 8'h20 : 8'h01);
            chk("arb_a", d3_alu_a, g ? 4'h5 : 4'hC);
            chk("arb_b", d3_alu_b, g ? 4'h7 : 4'hA);
            chk("arb_rdy_busy", d3_req0_ready | d3_req1_ready, 0);
         end
         tick(); #1;
         chk("arb_rsp0v", d3_rsp0_valid, {7'd0, !g});
         chk("arb_rsp1v", d3_rsp1_valid, {7'd0, g});
         chk("arb_y", g ? d3_rsp1_y : d3_rsp0_y, g ? 4'hE : 4'h8);
         chk("arb_c", g ? d3_rsp1_c : d3_rsp0_c, g ? 1 : 0);
         tick(); #1;
      end
      chk("arb_next_rdy0", d3_req0_ready, 1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
